// File: rtl/fft16_input_reorder_if.sv
// Stream-in / grouped-out bus of the FFT16 input reorder stage.
// The slave modport is the reorder block's view; master is the producer/consumer side.
interface fft16_input_reorder_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_real;
  logic [IN_W-1:0]  in_imag;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] a_real, a_imag, b_real, b_imag;
  logic [OUT_W-1:0] c_real, c_imag, d_real, d_imag;
  logic [1:0]       out_group;
  logic             out_last;

  modport slave (
    input  in_valid, in_real, in_imag, in_last, out_ready,
    output in_ready, out_valid, out_group, out_last,
    output a_real, a_imag, b_real, b_imag, c_real, c_imag, d_real, d_imag
  );

  modport master (
    output in_valid, in_real, in_imag, in_last, out_ready,
    input  in_ready, out_valid, out_group, out_last,
    input  a_real, a_imag, b_real, b_imag, c_real, c_imag, d_real, d_imag
  );
endinterface

// File: rtl/fft16_input_reorder.sv
// FFT16 input stage: buffers a 16-sample frame and emits four bit-reversed groups of four.
// Define FFT16_IN_PINGPONG_EN for two banks so a new frame fills while the previous one drains.
module fft16_input_reorder #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  fft16_input_reorder_if.slave bus,
  output logic                frame_err
);
  // In the ping-pong build FILL/DRAIN describe the read side only.
  typedef enum logic {FILL, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [3:0]       wr_cnt_q, wr_cnt_d;
  logic [1:0]       rd_grp_q, rd_grp_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;
  logic [OUT_W-1:0] op_re_q [4];
  logic [OUT_W-1:0] op_re_d [4];
  logic [OUT_W-1:0] op_im_q [4];
  logic [OUT_W-1:0] op_im_d [4];
  logic             in_fire, out_fire, frame_done, ld;
  logic [1:0]       ld_grp;
  logic [3:0]       rd_idx;

`ifdef FFT16_IN_PINGPONG_EN
  logic             wr_bank_q, wr_bank_d;
  logic             wr_full_q, wr_full_d;
  logic             ld_bank, drain_end;
  logic [IN_W-1:0]  mem_re [2][16];
  logic [IN_W-1:0]  mem_im [2][16];
`else
  logic [IN_W-1:0]  mem_re [16];
  logic [IN_W-1:0]  mem_im [16];
`endif

  function automatic logic [3:0] rev4(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v);
    return OUT_W'($signed(v));
  endfunction

`ifdef FFT16_IN_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[wr_bank_q][wr_cnt_q] <= bus.in_real;
      mem_im[wr_bank_q][wr_cnt_q] <= bus.in_imag;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[wr_cnt_q] <= bus.in_real;
      mem_im[wr_cnt_q] <= bus.in_imag;
    end
  end
`endif

  always_comb begin
    in_fire     = bus.in_valid && in_ready_q;
    out_fire    = out_valid_q && bus.out_ready;
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_grp_d    = rd_grp_q;
    frame_err_d = frame_err_q;
    frame_done  = 1'b0;
    ld          = 1'b0;
    ld_grp      = 2'd0;
    rd_idx      = 4'd0;

    // A short frame is dropped; a 16th sample without in_last still completes the frame.
    if (in_fire) begin
      if (wr_cnt_q == 4'd15) begin
        frame_done = 1'b1;
        wr_cnt_d   = 4'd0;
        if (!bus.in_last) frame_err_d = 1'b1;
      end else if (bus.in_last) begin
        wr_cnt_d    = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 4'd1;
      end
    end

`ifdef FFT16_IN_PINGPONG_EN
    wr_bank_d = wr_bank_q;
    wr_full_d = wr_full_q;
    ld_bank   = ~wr_bank_q;
    drain_end = out_fire && (rd_grp_q == 2'd3);
    if (out_fire && (rd_grp_q != 2'd3)) begin
      rd_grp_d = rd_grp_q + 2'd1;
      ld       = 1'b1;
      ld_grp   = rd_grp_q + 2'd1;
    end
    // Swap as soon as a full write bank meets an idle (or just-finished) read bank.
    if ((frame_done || wr_full_q) && ((state_q == FILL) || drain_end)) begin
      wr_bank_d = ~wr_bank_q;
      wr_full_d = 1'b0;
      state_d   = DRAIN;
      rd_grp_d  = 2'd0;
      ld        = 1'b1;
      ld_grp    = 2'd0;
      ld_bank   = wr_bank_q;
    end else if (frame_done || wr_full_q) begin
      wr_full_d = 1'b1;
    end else if (drain_end) begin
      state_d  = FILL;
      rd_grp_d = 2'd0;
    end
    in_ready_d = !wr_full_d;
`else
    if (frame_done) begin
      state_d  = DRAIN;
      rd_grp_d = 2'd0;
      ld       = 1'b1;
      ld_grp   = 2'd0;
    end else if (out_fire) begin
      if (rd_grp_q == 2'd3) begin
        state_d  = FILL;
        rd_grp_d = 2'd0;
      end else begin
        rd_grp_d = rd_grp_q + 2'd1;
        ld       = 1'b1;
        ld_grp   = rd_grp_q + 2'd1;
      end
    end
    in_ready_d = (state_d == FILL);
`endif

    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (rd_grp_d == 2'd3);

    for (int k = 0; k < 4; k++) begin
      op_re_d[k] = op_re_q[k];
      op_im_d[k] = op_im_q[k];
      if (ld) begin
        rd_idx = rev4({ld_grp, 2'(k)});
`ifdef FFT16_IN_PINGPONG_EN
        op_re_d[k] = sext(mem_re[ld_bank][rd_idx]);
        op_im_d[k] = sext(mem_im[ld_bank][rd_idx]);
`else
        op_re_d[k] = sext(mem_re[rd_idx]);
        op_im_d[k] = sext(mem_im[rd_idx]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_cnt_q    <= 4'd0;
      rd_grp_q    <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        op_re_q[k] <= '0;
        op_im_q[k] <= '0;
      end
`ifdef FFT16_IN_PINGPONG_EN
      wr_bank_q <= 1'b0;
      wr_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_grp_q    <= rd_grp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      for (int k = 0; k < 4; k++) begin
        op_re_q[k] <= op_re_d[k];
        op_im_q[k] <= op_im_d[k];
      end
`ifdef FFT16_IN_PINGPONG_EN
      wr_bank_q <= wr_bank_d;
      wr_full_q <= wr_full_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_group = rd_grp_q;
  assign bus.out_last  = out_last_q;
  assign bus.a_real    = op_re_q[0];
  assign bus.a_imag    = op_im_q[0];
  assign bus.b_real    = op_re_q[1];
  assign bus.b_imag    = op_im_q[1];
  assign bus.c_real    = op_re_q[2];
  assign bus.c_imag    = op_im_q[2];
  assign bus.d_real    = op_re_q[3];
  assign bus.d_imag    = op_im_q[3];
  assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_fft16_input_reorder.sv
// Self-checking bench for fft16_input_reorder: queue-based frame model plus directed corner cases.
module tb_fft16_input_reorder;
  localparam int IN_W  = 32;
  localparam int OUT_W = 64;

  logic clk = 1'b0;
  logic rst;
  logic frame_err;
  int   total = 0;
  int   bad   = 0;

  fft16_input_reorder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  fft16_input_reorder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       grp;
    logic [3:0][63:0] re;
    logic [3:0][63:0] im;
  } grp_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [63:0] exp_re;
    logic [63:0] exp_im;
  } vec_t;

  grp_t        expq[$];
  logic [31:0] cur_re[$];
  logic [31:0] cur_im[$];
  bit          exp_err;
  bit          count_stall;
  int          stall_cnt;
  bit          rand_done;
  logic [31:0] tx_re[16];
  logic [31:0] tx_im[16];

  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  function automatic logic [63:0] widen(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  // Frame model: collect accepted samples, on the 16th emit four bit-reversed groups.
  function automatic void modelAccept(input logic [31:0] re, input logic [31:0] im, input bit last);
    grp_t e;
    cur_re.push_back(re);
    cur_im.push_back(im);
    if (cur_re.size() == 16) begin
      if (!last) exp_err = 1'b1;
      for (int g = 0; g < 4; g++) begin
        e.grp = 2'(g);
        for (int k = 0; k < 4; k++) begin
          e.re[k] = widen(cur_re[bitrev(4 * g + k)]);
          e.im[k] = widen(cur_im[bitrev(4 * g + k)]);
        end
        expq.push_back(e);
      end
      cur_re.delete();
      cur_im.delete();
    end else if (last) begin
      exp_err = 1'b1;
      cur_re.delete();
      cur_im.delete();
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    grp_t act;
    grp_t e;
    if (rst) begin
      cur_re.delete();
      cur_im.delete();
      expq.delete();
      exp_err = 1'b0;
    end else begin
      if (count_stall && bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.in_valid && bus.in_ready) modelAccept(bus.in_real, bus.in_imag, bus.in_last);
      if (bus.out_valid && bus.out_ready) begin
        total++;
        act.grp = bus.out_group;
        act.re  = {bus.d_real, bus.c_real, bus.b_real, bus.a_real};
        act.im  = {bus.d_imag, bus.c_imag, bus.b_imag, bus.a_imag};
        if (expq.size() == 0) begin
          bad++;
          $display("[TB] FAIL spurious_group: got grp=%0d a_re=%h expected no group", act.grp, act.re[0]);
        end else begin
          e = expq.pop_front();
          if (act !== e || bus.out_last !== (e.grp == 2'd3)) begin
            bad++;
            $display("[TB] FAIL group: got grp=%0d last=%b a_re=%h d_im=%h expected grp=%0d a_re=%h d_im=%h",
                     act.grp, bus.out_last, act.re[0], act.im[3], e.grp, e.re[0], e.im[3]);
          end
        end
      end
    end
  end

  task automatic randomizeFrame();
    for (int n = 0; n < 16; n++) begin
      tx_re[n] = $urandom;
      tx_im[n] = $urandom;
    end
  endtask

  // Drive samples 0..last_at; returns #1 after the final sample's accepting edge.
  task automatic applyStimulus(input int last_at, input bit last_flag, input bit keep_valid, input bit gaps);
    int wait_cnt;
    for (int i = 0; i <= last_at; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_real  = tx_re[i];
      bus.in_imag  = tx_im[i];
      bus.in_last  = last_flag && (i == last_at);
      wait_cnt = 0;
      @(negedge clk);
      while (!bus.in_ready && wait_cnt < 200) begin
        wait_cnt++;
        @(negedge clk);
      end
      if (!bus.in_ready) begin
        checkOutput("in_ready_timeout", 64'd0, 64'd1);
        i = last_at;
      end
      @(posedge clk);
      #1;
    end
    if (!keep_valid) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((expq.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", 64'(expq.size() == 0 && !bus.out_valid), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   exp_stall;
    vecs[0] = '{32'h80000000, 32'h7FFFFFFF, 64'hFFFFFFFF80000000, 64'h000000007FFFFFFF};
    vecs[1] = '{32'h7FFFFFFF, 32'h80000000, 64'h000000007FFFFFFF, 64'hFFFFFFFF80000000};
    vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{32'h00000001, 32'hFFFFFFFE, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFE};
    vecs[4] = '{32'h12345678, 32'h87654321, 64'h0000000012345678, 64'hFFFFFFFF87654321};

    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    count_stall   = 1'b0;
    stall_cnt     = 0;
    rand_done     = 1'b0;
    rst           = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_group_last", 64'({bus.out_group, bus.out_last}), 64'd0);
    checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
    checkOutput("rst_operands", bus.a_real | bus.a_imag | bus.b_real | bus.b_imag |
                bus.c_real | bus.c_imag | bus.d_real | bus.d_imag, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_release_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] ramp frame");
    for (int n = 0; n < 16; n++) begin
      tx_re[n] = 32'(n);
      tx_im[n] = 32'(-n);
    end
    applyStimulus(15, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("lat_group", 64'(bus.out_group), 64'd0);
    checkOutput("lat_a_re", bus.a_real, 64'd0);
    checkOutput("lat_b_re", bus.b_real, 64'd8);
    checkOutput("lat_c_re", bus.c_real, 64'd4);
    checkOutput("lat_d_re", bus.d_real, 64'd12);
    checkOutput("lat_d_im", bus.d_imag, 64'hFFFFFFFFFFFFFFF4);
    waitDrain();

    $display("[TB] sign extension table");
    for (int v = 0; v < 5; v++) begin
      randomizeFrame();
      tx_re[0] = vecs[v].re;
      tx_im[0] = vecs[v].im;
      applyStimulus(15, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("sext%0d_re", v), bus.a_real, vecs[v].exp_re);
      checkOutput($sformatf("sext%0d_im", v), bus.a_imag, vecs[v].exp_im);
      waitDrain();
    end

    $display("[TB] backpressure at group 1");
    randomizeFrame();
    applyStimulus(15, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("stall_g1_grp", 64'(bus.out_group), 64'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("stall_hold_grp", 64'(bus.out_group), 64'd1);
      checkOutput("stall_hold_a_re", bus.a_real, widen(tx_re[2]));
      checkOutput("stall_hold_d_im", bus.d_imag, widen(tx_im[14]));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_g2_grp", 64'(bus.out_group), 64'd2);
    waitDrain();

    $display("[TB] short frame");
    randomizeFrame();
    applyStimulus(7, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("short_no_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("short_err", 64'(frame_err), 64'd1);
    randomizeFrame();
    applyStimulus(15, 1'b1, 1'b0, 1'b0);
    waitDrain();
    checkOutput("err_sticky", 64'(frame_err), 64'd1);
    checkOutput("err_model", 64'(frame_err), 64'(exp_err));

    $display("[TB] reset during group 2");
    randomizeFrame();
    applyStimulus(15, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_rst_grp", 64'(bus.out_group), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("mid_rst_err", 64'(frame_err), 64'd0);
    checkOutput("mid_rst_ops", bus.a_real | bus.b_imag | bus.c_real | bus.d_imag, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_rst_no_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] frame without in_last");
    randomizeFrame();
    applyStimulus(15, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("nolast_err", 64'(frame_err), 64'd1);

    $display("[TB] random frames with random backpressure");
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          randomizeFrame();
          applyStimulus(15, 1'b1, 1'b0, 1'b1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    waitDrain();

    $display("[TB] back-to-back frames");
    bus.out_ready = 1'b1;
    stall_cnt     = 0;
    count_stall   = 1'b1;
    for (int f = 0; f < 4; f++) begin
      randomizeFrame();
      applyStimulus(15, 1'b1, 1'b1, 1'b0);
    end
    count_stall  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    waitDrain();
`ifdef FFT16_IN_PINGPONG_EN
    exp_stall = 0;
`else
    exp_stall = 12;
`endif
    checkOutput("b2b_stalls", 64'(stall_cnt), 64'(exp_stall));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
